// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encoding and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width: enough to index WIDTH bits, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational single-bit full adder, the only arithmetic in the serial adder.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit adder that processes one bit per clock, LSB first,
// through a single fa_cell and a carry flop.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the 'sub' port (A - B).
//
// Handshake: 'start' is a request sampled only while IDLE; it is accepted on
// that edge and any start seen while busy or done is dropped (no queueing).
// 'done' is a one-cycle pulse; sum/cout/ovf are valid from that cycle and
// hold until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic               sub,
`endif
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  output logic               ovf,
  output logic [STATE_W-1:0] dbg_state
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   b_load;
  logic               c_load;
  logic               fa_s;
  logic               fa_co;
  logic               last_bit;

  // Operand conditioning at capture: subtraction is A + ~B + 1.
  always_comb begin
    b_load = b;
    c_load = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
`endif
  end

  fa_cell u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

  // State register and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the MSB, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: capture on accept, one bit per RUN cycle, publish on the MSB edge.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b_load;
          carry_d  = c_load;
          cnt_d    = '0;
          sum_sh_d = '0;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // New sum bit enters at the MSB end so after WIDTH shifts bit 0 is at the LSB.
        sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
        carry_d  = fa_co;
        if (last_bit) begin
          sum_d  = sum_sh_d;
          cout_d = fa_co;
          // carry_q here is the carry into the MSB.
          ovf_d  = carry_q ^ fa_co;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from state and result registers.
  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W   = 8;
  localparam int TMO = 64;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // WIDTH=8 DUT signals
  logic               start, cin, sub;
  logic [W-1:0]       a, b;
  logic               busy, done, cout, ovf;
  logic [W-1:0]       sum;
  logic [STATE_W-1:0] dbg_state;

  // WIDTH=1 DUT signals
  logic               start1, cin1, sub1;
  logic [0:0]         a1, b1, sum1;
  logic               busy1, done1, cout1, ovf1;
  logic [STATE_W-1:0] dbg_state1;

  int total = 0;
  int bad   = 0;

  logic [W+1:0] exp_q[$];
  logic [2:0]   exp1_q[$];
  logic [W+1:0] exp_e;
  logic [2:0]   exp1_e;
  logic         prev_done  = 1'b0;
  logic         prev_done1 = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub1),
`endif
    .busy      (busy1),
    .done      (done1),
    .sum       (sum1),
    .cout      (cout1),
    .ovf       (ovf1),
    .dbg_state (dbg_state1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor, WIDTH=8
  always @(negedge clk) begin
    if (done) begin
      chk("done_pulse", prev_done, 1'b0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 expected no pending result");
      end else begin
        exp_e = exp_q.pop_front();
        chk("sum",  sum,  exp_e[W-1:0]);
        chk("cout", cout, exp_e[W]);
        chk("ovf",  ovf,  exp_e[W+1]);
      end
    end
    prev_done = done;
  end

  // Scoreboard monitor, WIDTH=1
  always @(negedge clk) begin
    if (done1) begin
      chk("w1_done_pulse", prev_done1, 1'b0);
      if (exp1_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w1_spurious_done: got done=1 expected no pending result");
      end else begin
        exp1_e = exp1_q.pop_front();
        chk("w1_sum",  sum1,  exp1_e[0]);
        chk("w1_cout", cout1, exp1_e[1]);
        chk("w1_ovf",  ovf1,  exp1_e[2]);
      end
    end
    prev_done1 = done1;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || done) && n < TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= TMO) chk("idle_wait", {busy, done}, 2'b00);
  endtask

  // mode 0: plain op; mode 1: start re-asserted during RUN; mode 2: reset after bit 3
  task automatic do_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                       input logic cin_v, input logic sub_v,
                       input logic [W-1:0] es, input logic ec, input logic eo,
                       input logic [W-1:0] hold, input int mode);
    int j;
    int busy_cnt;
    bit fin;
    wait_idle();
    @(negedge clk);
    a = a_v;
    b = b_v;
    cin = cin_v;
    sub = sub_v;
    start = 1'b1;
    if (mode != 2) exp_q.push_back({eo, ec, es});
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_cnt = 0;
    fin = 1'b0;
    for (j = 0; j <= W + 4; j++) begin
      if (done) break;
      if (busy) busy_cnt++;
      if (j < W) chk("sum_hold", sum, hold);
      if (mode == 1 && j == 2) begin
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
      end
      if (mode == 1 && j == 4) start = 1'b0;
      if (mode == 2 && j == 4) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy",  busy,  1'b0);
        chk("rst_done",  done,  1'b0);
        chk("rst_sum",   sum,   '0);
        chk("rst_cout",  cout,  1'b0);
        chk("rst_ovf",   ovf,   1'b0);
        chk("rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!fin) begin
      chk("latency", j, W);
      chk("busy_cycles", busy_cnt, W);
      chk("busy_at_done", busy, 1'b0);
    end
  endtask

  task automatic do_op1(input logic a_v, input logic b_v, input logic c_v);
    logic [1:0] r;
    int j;
    int n;
    r = {1'b0, a_v} + {1'b0, b_v} + {1'b0, c_v};
    n = 0;
    while ((busy1 || done1) && n < TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= TMO) chk("w1_idle_wait", {busy1, done1}, 2'b00);
    @(negedge clk);
    a1 = a_v;
    b1 = b_v;
    cin1 = c_v;
    start1 = 1'b1;
    // WIDTH=1: carry into the MSB is cin itself
    exp1_q.push_back({c_v ^ r[1], r[1], r[0]});
    @(posedge clk);
    #1;
    start1 = 1'b0;
    chk("w1_busy", busy1, 1'b1);
    for (j = 0; j <= 5; j++) begin
      if (done1) break;
      @(posedge clk);
      #1;
    end
    chk("w1_latency", j, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;  a = '0;  b = '0;  cin = 1'b0;  sub = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",  busy,  1'b0);
    chk("reset_done",  done,  1'b0);
    chk("reset_sum",   sum,   '0);
    chk("reset_cout",  cout,  1'b0);
    chk("reset_ovf",   ovf,   1'b0);
    chk("reset_state", dbg_state, IDLE);
    chk("w1_reset_out", {busy1, done1, sum1, cout1, ovf1}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    //     a      b      cin   sub   sum    cout  ovf   hold   mode
    do_op(8'h3C, 8'h42, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0, 8'h00, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h7E, 0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 8'h00, 0);
    do_op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 0);
    do_op(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 0);
    do_op(8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 8'h00, 0);
    do_op(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 8'hFF, 1);
    do_op(8'h90, 8'h90, 1'b0, 1'b0, 8'h20, 1'b1, 1'b1, 8'h46, 0);
    do_op(8'h3C, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h20, 2);
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 8'h00, 0);
`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h02, 0);
    do_op(8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 8'hFE, 0);
    do_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h02, 0);
`endif

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      do_op1(v[2], v[1], v[0]);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("pending_w8", exp_q.size(), 0);
    chk("pending_w1", exp1_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder: captures two WIDTH-bit operands on a start request and adds them LSB-first, one bit per clock, through a single full-adder cell and a carry flop. Reports sum, carry-out and signed overflow with a one-cycle done pulse. It is the sequential, area-minimal successor to the combinational single-bit full adder, intended for datapaths where latency is cheap and adder width must scale without growing logic.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..64
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- sub  input  1  subtract select, captured on accepted start; present only with SERIAL_ADDER_SUB_EN
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when result is valid
- sum  output  WIDTH  result, held until next completion
- cout  output  1  carry out of MSB, held
- ovf  output  1  signed overflow (carry into MSB xor carry out of MSB), held

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on start=1, load A/B shift registers, load carry flop with cin, clear bit counter, go to RUN. start=0: stay.
- RUN: each cycle, full-adder on (a_sh[0], b_sh[0], carry); sum bit shifted into sum_sh at MSB end (right shift); carry flop updated; A/B shift right; counter increments. On the edge that processes bit WIDTH-1, record carry-in of that bit as msb_cin, transfer sum_sh/final carry to sum/cout, set ovf = msb_cin ^ final carry, go to DONE.
- DONE: done=1 for exactly one cycle, unconditional return to IDLE.
- start in RUN or DONE is ignored; no queueing.
- sum/cout/ovf change only on the completion edge; never show partial results.
- Arithmetic is modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
- WIDTH=1: RUN lasts one cycle; ovf = cin ^ cout.

## Timing
- Reset (async assert, any state incl. mid-RUN): state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; shift registers, carry, counter cleared. Deassertion is taken synchronously to clk by the surrounding design.
- Accepting edge k: busy=1 from after edge k through edge k+WIDTH.
- Bit i processed at edge k+1+i.
- Result registered at edge k+WIDTH; done=1 and busy=0 in the following cycle.
- Start-to-done latency: WIDTH cycles; next start accepted no earlier than edge k+WIDTH+2 (throughput one operation per WIDTH+2 cycles).
- Counter width $clog2(WIDTH) with minimum 1; no wrap beyond WIDTH-1.

## Configuration
- SERIAL_ADDER_SUB_EN defined: sub port exists; if sub=1 at accepted start, B is captured bitwise inverted and carry flop loaded with 1 (cin ignored); cout=1 means no borrow; ovf is signed subtraction overflow.
- Undefined: no sub port; addition only; behaviour identical to sub=0.

## Structure
- Package serial_adder_pkg: state enum (IDLE, RUN, DONE) and state width constant.
- Sub-module fa_cell: combinational 1-bit full adder (a, b, ci -> s, co), instantiated once.
- Top holds FSM, shift registers, carry flop, counter, output registers.

## Test plan
- WIDTH=8, a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0, ovf=0; done exactly 8 cycles after start edge, busy high 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0; a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1; a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1.
- start re-asserted during RUN with a=0x11, b=0x22 -> ignored, first result reported; sum holds prior value during RUN until completion edge.
- rst_n pulsed low after bit 3 -> busy, done, sum, cout, ovf =0 immediately; next start 0x01+0x01 -> 0x02 with normal latency.
- SERIAL_ADDER_SUB_EN, sub=1: 0x05-0x07 -> sum=0xFE, cout=0; 0x07-0x05 -> sum=0x02, cout=1; 0x80-0x01 -> sum=0x7F, ovf=1. Also WIDTH=1 exhaustive over all 8 (a, b, cin) combinations.
